// File: rtl/led_display_pkg.sv
// -----------------------------------------------------------------------------
// led_display_pkg
// Shared definitions for the LED display formatter:
//   - state_t     : formatter FSM state encoding
//   - SEG_TABLE   : active-low segment bytes {a,b,c,d,e,f,g,DP} for 0..F
//   - SEG_BLANK   : all segments off
//   - SEG_DASH    : only segment g lit
//   - DEC_MAX     : largest value representable on four decimal digits
// -----------------------------------------------------------------------------
package led_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    ENCODE  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;

  // DP bit (bit 0) is off in every entry; the encoder clears it on demand.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  localparam logic [15:0] DEC_MAX        = 16'd9999;
  localparam logic [3:0]  LAST_ITERATION = 4'd15;

endpackage

// File: rtl/seg7_encoder.sv
// -----------------------------------------------------------------------------
// seg7_encoder
// Purely combinational nibble to seven-segment encoder.
// Ports:
//   nibble : 4-bit digit value (0..F)
//   blank  : 1 = all segments off (decimal point still honoured)
//   dp     : 1 = light the decimal point
//   seg    : active-low segment byte {a,b,c,d,e,f,g,DP}
// -----------------------------------------------------------------------------
module seg7_encoder
  import led_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  // Active-low: clearing bit 0 lights the point, even on a blanked digit.
  assign seg = (blank ? SEG_BLANK : SEG_TABLE[nibble]) & {7'h7F, ~dp};

endmodule

// File: rtl/led_display_formatter.sv
// -----------------------------------------------------------------------------
// led_display_formatter
// Formats a 16-bit binary value into four active-low seven-segment bytes,
// either as hex (one nibble per digit) or as decimal via a 16-cycle
// double-dabble conversion. Decimal values above 9999 show four dashes and
// raise o_overflow.
// Parameters:
//   BLANK_LEADING_ZEROS : 1 = blank leading zero digits D3..D1
// Ports:
//   i_clk, i_reset_n    : clock, synchronous active-low reset
//   i_stb               : request strobe, accepted only while o_busy = 0
//   i_value, i_mode     : value to show; radix (0 = hex, 1 = decimal)
//   i_dp                : per-digit decimal point enables
//   o_busy              : request in progress
//   o_display_D0..D3    : segment bytes, D0 = least significant digit
//   o_done              : one-cycle pulse when new digits are presented
//   o_overflow          : last decimal request exceeded 9999
// -----------------------------------------------------------------------------
module led_display_formatter
  import led_display_pkg::*;
#(
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stb,
  output logic        o_busy,
  input  logic [15:0] i_value,
  input  logic        i_mode,
  input  logic [3:0]  i_dp,
  output logic [7:0]  o_display_D0,
  output logic [7:0]  o_display_D1,
  output logic [7:0]  o_display_D2,
  output logic [7:0]  o_display_D3,
  output logic        o_done,
  output logic        o_overflow
);

  state_t      state;
  logic [15:0] value_q;
  logic        mode_q;
  logic [3:0]  dp_q;
  logic [3:0]  iter_q;

  // Double-dabble working register: BCD digits in [35:16], binary in [15:0].
  logic [35:0] dd_q;
  logic [35:0] dd_adj;

  logic [3:0]  digit [4];
  logic [3:0]  blank;
  logic [7:0]  seg   [4];
  logic        ovf_next;

  assign o_busy = (state != IDLE);

  // Add-3 correction on every BCD digit that is 5 or more, ahead of the shift.
  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    dd_adj = dd_q;
    for (int i = 0; i < 5; i++) begin
      if (dd_q[16 + 4*i +: 4] >= 4'd5) begin
        dd_adj[16 + 4*i +: 4] = dd_q[16 + 4*i +: 4] + 4'd3;
      end
    end
  end

  assign ovf_next = mode_q && (value_q > DEC_MAX);

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      digit[n] = mode_q ? dd_q[16 + 4*n +: 4] : value_q[4*n +: 4];
    end
    // A digit blanks only if it and every digit above it are zero.
    blank[3] = BLANK_LEADING_ZEROS && (digit[3] == 4'd0);
    blank[2] = blank[3] && (digit[2] == 4'd0);
    blank[1] = blank[2] && (digit[1] == 4'd0);
    blank[0] = 1'b0;
  end

  for (genvar g = 0; g < 4; g++) begin : g_enc
    seg7_encoder u_seg7_encoder (
      .nibble (digit[g]),
      .blank  (blank[g]),
      .dp     (dp_q[g]),
      .seg    (seg[g])
    );
  end

  function automatic logic [7:0] pick(input logic [7:0] enc, input logic dp);
    return ovf_next ? (SEG_DASH & {7'h7F, ~dp}) : enc;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      o_display_D0 <= SEG_BLANK;
      o_display_D1 <= SEG_BLANK;
      o_display_D2 <= SEG_BLANK;
      o_display_D3 <= SEG_BLANK;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      // NOTE: the datapath registers are deliberately not reset; each is
      // loaded on request accept before anything reads it.
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_stb) begin
            value_q <= i_value;
            mode_q  <= i_mode;
            dp_q    <= i_dp;
            dd_q    <= {20'd0, i_value};
            iter_q  <= 4'd0;
            state   <= i_mode ? CONVERT : ENCODE;
          end
        end
        CONVERT: begin
          dd_q   <= dd_adj << 1;
          iter_q <= iter_q + 4'd1;
          if (iter_q == LAST_ITERATION) begin
            state <= ENCODE;
          end
        end
        ENCODE: begin
          o_display_D0 <= pick(seg[0], dp_q[0]);
          o_display_D1 <= pick(seg[1], dp_q[1]);
          o_display_D2 <= pick(seg[2], dp_q[2]);
          o_display_D3 <= pick(seg[3], dp_q[3]);
          o_overflow   <= ovf_next;
          o_done       <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_display_formatter.sv
// -----------------------------------------------------------------------------
// tb_led_display_formatter
// Self-checking bench: directed vector table, randomized requests against a
// behavioural model, and hand-written reset / busy-drop sequences.
// -----------------------------------------------------------------------------
module tb_led_display_formatter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stb = 1'b0;
  logic [15:0] value = '0;
  logic        mode = 1'b0;
  logic [3:0]  dp_in = '0;
  logic        busy, done, overflow;
  logic [7:0]  d0, d1, d2, d3;

  int pass_cnt = 0;
  int total_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  logic [7:0] seg_ref [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  led_display_formatter #(.BLANK_LEADING_ZEROS(1'b1)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_stb        (stb),
    .o_busy       (busy),
    .i_value      (value),
    .i_mode       (mode),
    .i_dp         (dp_in),
    .o_display_D0 (d0),
    .o_display_D1 (d1),
    .o_display_D2 (d2),
    .o_display_D3 (d3),
    .o_done       (done),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model: digits by integer division in the chosen radix; a leading digit
  // blanks when the whole value is below that digit's weight.
  function automatic logic [32:0] model(input logic [15:0] v, input logic m, input logic [3:0] dp);
    logic [32:0] r;
    logic [7:0]  s;
    int base, scale, dig;
    logic ovf;
    base  = m ? 10 : 16;
    ovf   = m && (int'(v) > 9999);
    scale = 1;
    r     = '0;
    for (int n = 0; n < 4; n++) begin
      dig = (int'(v) / scale) % base;
      if (ovf) s = 8'hFD;
      else if (n > 0 && int'(v) < scale) s = 8'hFF;
      else s = seg_ref[dig];
      if (dp[n]) s[0] = 1'b0;
      r[8*n +: 8] = s;
      scale = scale * base;
    end
    r[32] = ovf;
    return r;
  endfunction

  task automatic run_req(input logic [15:0] v, input logic m, input logic [3:0] dp,
                         output int lat, output int busy_n, output int done_n,
                         output logic [31:0] seg, output logic ovf, output logic [31:0] seg_late);
    int b0, n0;
    @(negedge clk);
    b0 = busy_cnt; n0 = done_cnt;
    stb = 1'b1; value = v; mode = m; dp_in = dp;
    @(negedge clk);
    stb = 1'b0; value = 16'($urandom); mode = 1'($urandom); dp_in = 4'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    seg = {d3, d2, d1, d0};
    ovf = overflow;
    repeat (2) @(negedge clk);
    #1;
    seg_late = {d3, d2, d1, d0};
    busy_n = busy_cnt - b0;
    done_n = done_cnt - n0;
  endtask

  typedef struct {
    logic [15:0] v;
    logic        m;
    logic [3:0]  dp;
    logic [31:0] exp_seg;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat, bn, dn, cnt, n0;
    logic [31:0] seg, seg_late;
    logic ovf;
    logic [32:0] exp;
    logic [15:0] rv;
    logic rm;
    logic [3:0] rdp;

    vecs[0] = '{16'h1A2F, 1'b0, 4'b0000, 32'h9F11_2571, 1'b0, 1};
    vecs[1] = '{16'd1234, 1'b1, 4'b0000, 32'h9F25_0D99, 1'b0, 17};
    vecs[2] = '{16'd42,   1'b1, 4'b0001, 32'hFFFF_9924, 1'b0, 17};
    vecs[3] = '{16'h0000, 1'b0, 4'b0000, 32'hFFFF_FF03, 1'b0, 1};
    vecs[4] = '{16'd12345, 1'b1, 4'b0000, 32'hFDFD_FDFD, 1'b1, 17};
    vecs[5] = '{16'd7,    1'b1, 4'b0000, 32'hFFFF_FF1F, 1'b0, 17};
    vecs[6] = '{16'hFFFF, 1'b0, 4'b1111, 32'h7070_7070, 1'b0, 1};
    vecs[7] = '{16'd9999, 1'b1, 4'b0000, 32'h0909_0909, 1'b0, 17};
    vecs[8] = '{16'd10000, 1'b1, 4'b1010, 32'hFCFD_FCFD, 1'b1, 17};
    vecs[9] = '{16'h0000, 1'b0, 4'b1111, 32'hFEFE_FE02, 1'b0, 1};

    // Reset with a strobe asserted: nothing may start.
    reset_n = 1'b0; stb = 1'b1; mode = 1'b1; value = 16'd1234;
    repeat (3) @(negedge clk);
    check("reset seg", {d3, d2, d1, d0}, 32'hFFFF_FFFF);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ovf", 32'(overflow), 32'd0);
    stb = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    check("post-reset busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].v, vecs[i].m, vecs[i].dp, lat, bn, dn, seg, ovf, seg_late);
      check($sformatf("vec%0d seg", i), seg, vecs[i].exp_seg);
      check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d busy cycles", i), 32'(bn), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d done pulses", i), 32'(dn), 32'd1);
      check($sformatf("vec%0d hold", i), seg_late, vecs[i].exp_seg);
    end

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: rv = 16'($urandom);
        1: rv = 16'($urandom_range(0, 9999));
        2: rv = 16'($urandom_range(0, 99));
        default: rv = 16'($urandom_range(0, 15));
      endcase
      rm  = 1'($urandom);
      rdp = 4'($urandom);
      exp = model(rv, rm, rdp);
      run_req(rv, rm, rdp, lat, bn, dn, seg, ovf, seg_late);
      check($sformatf("rand%0d seg v=%h m=%0d", i, rv, rm), seg, exp[31:0]);
      check($sformatf("rand%0d ovf", i), 32'(ovf), 32'(exp[32]));
      check($sformatf("rand%0d latency", i), 32'(lat), rm ? 32'd17 : 32'd1);
    end

    // Second strobe at edge k+3 while converting 1234 must be dropped.
    @(negedge clk);
    n0 = done_cnt;
    stb = 1'b1; value = 16'd1234; mode = 1'b1; dp_in = 4'b0000;
    @(negedge clk);
    stb = 1'b0; cnt = 0;
    repeat (2) begin @(negedge clk); cnt++; end
    stb = 1'b1; value = 16'hFFFF; mode = 1'b0; dp_in = 4'b1111;
    @(negedge clk); cnt++;
    stb = 1'b0;
    while (!done && cnt < 40) begin @(negedge clk); cnt++; end
    check("drop latency", 32'(cnt), 32'd17);
    check("drop seg", {d3, d2, d1, d0}, 32'h9F25_0D99);
    repeat (20) @(negedge clk);
    #1;
    check("drop done pulses", 32'(done_cnt - n0), 32'd1);
    check("drop idle", 32'(busy), 32'd0);

    // Leave overflow set, then reset at edge k+8 of a conversion.
    run_req(16'd50000, 1'b1, 4'b0000, lat, bn, dn, seg, ovf, seg_late);
    check("pre-reset ovf", 32'(ovf), 32'd1);
    @(negedge clk);
    n0 = done_cnt;
    stb = 1'b1; value = 16'd1234; mode = 1'b1; dp_in = 4'b0000;
    @(negedge clk);
    stb = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort seg", {d3, d2, d1, d0}, 32'hFFFF_FFFF);
    check("abort busy", 32'(busy), 32'd0);
    check("abort ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    check("abort no done", 32'(done_cnt - n0), 32'd0);
    check("abort seg held", {d3, d2, d1, d0}, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/led_display_formatter.md
LED_DISPLAY_FORMATTER -- requirements
Module: led_display_formatter

Interface
REQ-001 SHALL have parameter BLANK_LEADING_ZEROS, default 1, meaning leading-zero blanking is enabled (0 = all four digits always shown).
REQ-002 SHALL have port i_clk, input, 1, the system clock; all logic is on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1, reset (synchronous, active-low).
REQ-004 SHALL have port i_stb, input, 1, request strobe (valid).
REQ-005 SHALL have port o_busy, output, 1, high while a request is in progress; requests are accepted only when it is low.
REQ-006 SHALL have port i_value, input, 16, the binary value to display.
REQ-007 SHALL have port i_mode, input, 1, display radix (0 = hex, 1 = decimal).
REQ-008 SHALL have port i_dp, input, 4, per-digit decimal point (bit n = digit Dn; 1 = point lit).
REQ-009 SHALL have ports o_display_D0..o_display_D3, output, 8 each, segment bytes in the order {a,b,c,d,e,f,g,DP}, active-low (0 = on), D0 = least-significant digit; these feed the downstream display controller directly.
REQ-010 SHALL have port o_done, output, 1, a one-cycle pulse when new digits are presented.
REQ-011 SHALL have port o_overflow, output, 1, set when a decimal value exceeds 9999.

Function
REQ-012 SHALL accept a request on a rising edge where i_reset_n=1, i_stb=1 and o_busy=0, capturing i_value, i_mode and i_dp on that edge (edge k).
REQ-013 SHALL ignore i_stb while o_busy=1; the request is dropped, not queued, and captured data is unaffected.
REQ-014 SHALL use FSM states IDLE, CONVERT and ENCODE; IDLE goes to ENCODE on accept when i_mode=0, or to CONVERT when i_mode=1; CONVERT goes to ENCODE after 16 cycles; ENCODE goes to IDLE.
REQ-015 SHALL drive o_busy=1 exactly when the state is not IDLE.
REQ-016 SHALL, in CONVERT, perform a 16-iteration shift-and-add-3 (double-dabble) into a 20-bit, 5-digit BCD register, one iteration per cycle.
REQ-017 SHALL, in ENCODE, register all four outputs, o_overflow and o_done=1 together; latency is hex = outputs valid after edge k+1, decimal = after edge k+17.
REQ-018 SHALL hold the outputs stable between updates; o_done SHALL be 0 in every other cycle.
REQ-019 SHALL use this nibble encoding with DP off: 0..F = 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71 (hex), dash = FD, blank = FF.
REQ-020 SHALL, in hex mode, map the nibble value[4n+3:4n] to digit Dn.
REQ-021 SHALL, in decimal mode, map BCD digit n to Dn when value <= 9999.
REQ-022 SHALL, in decimal mode when value > 9999, show a dash on all four digits, set o_overflow=1 and apply i_dp; o_overflow is cleared at the next ENCODE that is not an overflow.
REQ-023 SHALL, when BLANK_LEADING_ZEROS=1, blank digit Dn (n = 3..1) if it and all higher digits are zero; D0 is never blanked; this applies in both modes.
REQ-024 SHALL clear bit0 of Dn when i_dp[n]=1, including on blanked and dash digits.

Reset
REQ-025 SHALL, with i_reset_n=0 at an edge, set the state to IDLE, all o_display_Dn to 8'hFF, and o_done, o_overflow and o_busy to 0.
REQ-026 SHALL, on reset mid-CONVERT or mid-ENCODE, abort the request with no o_done, leaving the outputs at their reset values.
REQ-027 SHALL ignore i_stb on a reset edge.

Structure
REQ-028 SHALL place in shared package led_display_pkg: the 16-entry segment table, the SEG_BLANK (FF) and SEG_DASH (FD) constants, and the FSM state encoding.
REQ-029 SHALL contain one combinational sub-module, seg7_encoder (4-bit nibble plus blank and dp in, 8-bit segment byte out), instantiated four times.
REQ-030 SHALL be 120-400 lines of RTL in total.

Verification
REQ-031 SHALL cover: hex 0x1A2F, i_dp=0 -> after edge k+1, D3..D0 = 9F,11,25,71, o_done pulses once, o_busy high for 1 cycle.
REQ-032 SHALL cover: decimal 1234 -> o_busy high for 17 cycles, D3..D0 = 9F,25,0D,99 after edge k+17, o_overflow=0.
REQ-033 SHALL cover: decimal 42, i_dp=4'b0001 -> D3..D0 = FF,FF,99,24; hex 0x0000 -> FF,FF,FF,03.
REQ-034 SHALL cover: decimal 12345 -> D3..D0 = FD,FD,FD,FD and o_overflow=1; then decimal 7 -> FF,FF,FF,1F and o_overflow=0.
REQ-035 SHALL cover: second i_stb at k+3 during decimal 1234 -> ignored, with exactly one o_done and the 1234 result.
REQ-036 SHALL cover: reset at k+8 of a conversion -> next cycle all Dn = FF, o_busy=0, and no o_done pulse.
